// File: rtl/axis_dist_ram_pkt_fifo.sv
// Single-clock AXI-Stream FIFO held in LUT RAM, carrying full sideband, with optional
// store-and-forward packet mode, whole-packet drop on overflow, fill level and almost-full.
module axis_dist_ram_pkt_fifo #(
  parameter int unsigned DATA_BYTES         = 8,
  parameter int unsigned USER_WIDTH         = 1,
  parameter int unsigned ID_WIDTH           = 1,
  parameter int unsigned DEST_WIDTH         = 1,
  parameter int unsigned DEPTH              = 32,
  parameter bit          PACKET_MODE        = 1'b1,
  parameter bit          ALLOW_BACKPRESSURE = 1'b1,
  parameter bit          OUTPUT_REG         = 1'b1,
  parameter int unsigned ALMOST_FULL_THRESH = DEPTH - 4,
  localparam int unsigned LVL_W             = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic [DATA_BYTES*8-1:0] s_tdata,
  input  logic [DATA_BYTES-1:0]   s_tkeep,
  input  logic                    s_tlast,
  input  logic [USER_WIDTH-1:0]   s_tuser,
  input  logic [ID_WIDTH-1:0]     s_tid,
  input  logic [DEST_WIDTH-1:0]   s_tdest,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [DATA_BYTES*8-1:0] m_tdata,
  output logic [DATA_BYTES-1:0]   m_tkeep,
  output logic                    m_tlast,
  output logic [USER_WIDTH-1:0]   m_tuser,
  output logic [ID_WIDTH-1:0]     m_tid,
  output logic [DEST_WIDTH-1:0]   m_tdest,
  output logic [LVL_W-1:0]        level,
  output logic                    almost_full,
  output logic                    overflow_drop,
  output logic                    oversize_drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = DATA_BYTES * 8;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] PTR_ONE   = LVL_W'(1);

  if ((DEPTH < 4) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("axis_dist_ram_pkt_fifo: DEPTH must be a power of 2 in the range 4..256");
  end

  typedef struct packed {
    logic [DW-1:0]         data;
    logic [DATA_BYTES-1:0] keep;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
    logic [ID_WIDTH-1:0]   id;
    logic [DEST_WIDTH-1:0] dest;
  } word_t;

  typedef enum logic {
    ST_WRITE = 1'b0,
    ST_DROP  = 1'b1
  } state_t;

  word_t mem [DEPTH];

  logic [LVL_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] commit_ptr_q, commit_ptr_d;
  logic [LVL_W-1:0] rd_ptr_q, rd_ptr_d;
  state_t           state_q, state_d;
  logic             drop_oversize_q, drop_oversize_d;
  logic             overflow_drop_q, overflow_drop_d;
  logic             oversize_drop_q, oversize_drop_d;
  logic             rst_done_q, rst_done_d;

  logic [LVL_W-1:0] level_w;
  logic             full;
  logic             avail;
  logic             s_ready;
  logic             s_accept;
  logic             ram_we;
  logic             pop;
  logic             m_valid;
  word_t            s_word;
  word_t            rd_word;
  word_t            m_word;

  assign s_word  = {s_tdata, s_tkeep, s_tlast, s_tuser, s_tid, s_tdest};
  assign level_w = wr_ptr_q - rd_ptr_q;
  assign full    = (level_w == DEPTH_LVL);
  assign avail   = (rd_ptr_q != commit_ptr_q);
  assign rd_word = mem[rd_ptr_q[AW-1:0]];

  // Ready stays low until the first clock after reset release; DROP always swallows beats.
  always_comb begin
    s_ready = rst_done_q;
    if (ALLOW_BACKPRESSURE) begin
      s_ready = rst_done_q && ((state_q == ST_DROP) || !full);
    end
  end

  assign s_accept = s_tvalid && s_ready;

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    commit_ptr_d    = commit_ptr_q;
    drop_oversize_d = drop_oversize_q;
    overflow_drop_d = 1'b0;
    oversize_drop_d = 1'b0;
    ram_we          = 1'b0;
    rst_done_d      = 1'b1;
    case (state_q)
      ST_WRITE: begin
        // A full RAM holding only one unfinished packet can never drain: abandon that packet.
        if (PACKET_MODE && full && (commit_ptr_q == rd_ptr_q)) begin
          wr_ptr_d = commit_ptr_q;
          if (s_accept && s_tlast) begin
            oversize_drop_d = 1'b1;
          end else begin
            state_d         = ST_DROP;
            drop_oversize_d = 1'b1;
          end
        end else if (s_accept && full) begin
          if (PACKET_MODE) begin
            wr_ptr_d = commit_ptr_q;
          end
          if (s_tlast) begin
            overflow_drop_d = 1'b1;
          end else begin
            state_d         = ST_DROP;
            drop_oversize_d = 1'b0;
          end
        end else if (s_accept) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          if (s_tlast) begin
            commit_ptr_d = wr_ptr_q + PTR_ONE;
          end
        end
      end
      ST_DROP: begin
        if (s_accept && s_tlast) begin
          state_d = ST_WRITE;
          if (drop_oversize_q) begin
            oversize_drop_d = 1'b1;
          end else begin
            overflow_drop_d = 1'b1;
          end
        end
      end
      default: state_d = ST_WRITE;
    endcase
    if (!PACKET_MODE) begin
      commit_ptr_d = wr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q        <= '0;
      commit_ptr_q    <= '0;
      rd_ptr_q        <= '0;
      state_q         <= ST_WRITE;
      drop_oversize_q <= 1'b0;
      overflow_drop_q <= 1'b0;
      oversize_drop_q <= 1'b0;
      rst_done_q      <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      commit_ptr_q    <= commit_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      state_q         <= state_d;
      drop_oversize_q <= drop_oversize_d;
      overflow_drop_q <= overflow_drop_d;
      oversize_drop_q <= oversize_drop_d;
      rst_done_q      <= rst_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[wr_ptr_q[AW-1:0]] <= s_word;
    end
  end

  if (OUTPUT_REG) begin : g_out_reg
    word_t out_word_q, out_word_d;
    logic  out_valid_q, out_valid_d;
    logic  load;

    // Refill whenever the register is empty or its word is being taken this cycle.
    always_comb begin
      load        = avail && (!out_valid_q || m_tready);
      out_word_d  = out_word_q;
      out_valid_d = out_valid_q;
      if (load) begin
        out_word_d  = rd_word;
        out_valid_d = 1'b1;
      end else if (m_tready) begin
        out_valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= out_valid_d;
      end
    end

    always_ff @(posedge clk) begin
      out_word_q <= out_word_d;
    end

    assign pop     = load;
    assign m_valid = out_valid_q;
    assign m_word  = out_word_q;
  end else begin : g_out_direct
    assign pop     = avail && m_tready;
    assign m_valid = avail;
    assign m_word  = rd_word;
  end

  assign rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

  assign s_tready      = s_ready;
  assign m_tvalid      = m_valid;
  assign {m_tdata, m_tkeep, m_tlast, m_tuser, m_tid, m_tdest} = m_word;
  assign level         = level_w;
  assign almost_full   = (32'(level_w) >= ALMOST_FULL_THRESH);
  assign overflow_drop = overflow_drop_q;
  assign oversize_drop = oversize_drop_q;

endmodule

// File: tb/tb_axis_dist_ram_pkt_fifo.sv
// Self-checking bench for axis_dist_ram_pkt_fifo: four DEPTH=16 configurations share one
// stimulus bus, and each test resets and observes the instance selected by 'sel'.
module tb_axis_dist_ram_pkt_fifo;

   // Instance configuration, bit g belongs to instance g:
   //  0 = PKT1/BP1/OREG1, 1 = PKT0/BP1/OREG1, 2 = PKT1/BP0/OREG0, 3 = PKT0/BP1/OREG0
   localparam logic [3:0] PKT_V  = 4'b0101;
   localparam logic [3:0] BP_V   = 4'b1011;
   localparam logic [3:0] OREG_V = 4'b0011;

   typedef struct packed {
      logic [15:0] data;
      logic [1:0]  keep;
      logic        last;
      logic [1:0]  user;
      logic [1:0]  id;
      logic [2:0]  dest;
   } word_t;

   typedef struct {
      logic       sValid;
      word_t      sWord;
      logic       mReady;
      logic       expSReady;
      logic       expMValid;
      logic [4:0] expLevel;
      word_t      expWord;
   } vec_t;

   logic clk = 1'b0;
   logic aresetn;
   logic s_tvalid;
   logic m_tready;
   word_t s_word;
   logic [1:0] sel;

   logic [3:0]       s_tready_w, m_tvalid_w, m_tlast_w, almost_full_w, ovf_w, osz_w;
   logic [3:0][15:0] m_tdata_w;
   logic [3:0][1:0]  m_tkeep_w, m_tuser_w, m_tid_w;
   logic [3:0][2:0]  m_tdest_w;
   logic [3:0][4:0]  level_w;

   logic       s_tready_s, m_tvalid_s, almost_full_s, ovf_s, osz_s;
   logic [4:0] level_s;
   word_t      m_word_s;

   int    tests = 0;
   int    failed = 0;
   word_t rx_q[$];
   int    ovfCnt = 0;
   int    oszCnt = 0;
   int    holdErr = 0;
   bit    holdArmed = 0;
   word_t holdWord;
   bit    randDone;

   always #5 clk = ~clk;

   // One DUT per configuration; all share the input bus and differ only in parameters
   for (genvar g = 0; g < 4; g++) begin : g_dut
      axis_dist_ram_pkt_fifo #(
         .DATA_BYTES(2), .USER_WIDTH(2), .ID_WIDTH(2), .DEST_WIDTH(3), .DEPTH(16),
         .PACKET_MODE(PKT_V[g]), .ALLOW_BACKPRESSURE(BP_V[g]), .OUTPUT_REG(OREG_V[g])
      ) u_dut (
         .clk(clk), .aresetn(aresetn),
         .s_tvalid(s_tvalid), .s_tready(s_tready_w[g]),
         .s_tdata(s_word.data), .s_tkeep(s_word.keep), .s_tlast(s_word.last),
         .s_tuser(s_word.user), .s_tid(s_word.id), .s_tdest(s_word.dest),
         .m_tvalid(m_tvalid_w[g]), .m_tready(m_tready),
         .m_tdata(m_tdata_w[g]), .m_tkeep(m_tkeep_w[g]), .m_tlast(m_tlast_w[g]),
         .m_tuser(m_tuser_w[g]), .m_tid(m_tid_w[g]), .m_tdest(m_tdest_w[g]),
         .level(level_w[g]), .almost_full(almost_full_w[g]),
         .overflow_drop(ovf_w[g]), .oversize_drop(osz_w[g])
      );
   end

   assign s_tready_s    = s_tready_w[sel];
   assign m_tvalid_s    = m_tvalid_w[sel];
   assign almost_full_s = almost_full_w[sel];
   assign ovf_s         = ovf_w[sel];
   assign osz_s         = osz_w[sel];
   assign level_s       = level_w[sel];
   assign m_word_s      = {m_tdata_w[sel], m_tkeep_w[sel], m_tlast_w[sel],
                           m_tuser_w[sel], m_tid_w[sel], m_tdest_w[sel]};

   // Monitor on the falling edge: capture output handshakes, count drop pulses,
   // and flag any change of the output word while it is stalled
   always @(negedge clk) begin
      if (!aresetn) begin
         holdArmed = 0;
      end else begin
         if (holdArmed && (!m_tvalid_s || (m_word_s !== holdWord))) holdErr++;
         holdArmed = m_tvalid_s && !m_tready;
         holdWord  = m_word_s;
         if (m_tvalid_s && m_tready) rx_q.push_back(m_word_s);
         if (ovf_s) ovfCnt++;
         if (osz_s) oszCnt++;
      end
   end

   // Hard stop in case something hangs despite the bounded waits
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Deterministic test word carrying distinct data and sideband for index i
   function automatic word_t mk(input int i, input bit last);
      word_t w;
      logic [31:0] v;
      v      = i;
      w.data = 16'(v * 37 + 32'h1234);
      w.keep = last ? 2'b01 : 2'b11;
      w.last = last;
      w.user = v[1:0];
      w.id   = v[3:2];
      w.dest = v[6:4];
      return w;
   endfunction

   // Single comparison point: every check goes through here and steps the counters
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one table record onto the shared bus
   task automatic applyStimulus(input vec_t v);
      s_tvalid = v.sValid;
      s_word   = v.sWord;
      m_tready = v.mReady;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold a beat until the selected instance accepts it, within a cycle budget
   task automatic sendBeat(input word_t w);
      bit ok;
      ok       = 0;
      s_tvalid = 1'b1;
      s_word   = w;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (s_tready_s) ok = 1;
         tick();
         if (ok) break;
      end
      s_tvalid = 1'b0;
      if (!ok) checkOutput("send_timeout", 32'(ok), 32'd1);
   endtask

   // Wait (bounded) until n words have been captured, then check the count
   task automatic waitRx(input string name, input int n, input int budget);
      for (int k = 0; k < budget && rx_q.size() < n; k++) tick();
      checkOutput(name, rx_q.size(), n);
   endtask

   task automatic clearMonitor();
      rx_q.delete();
      ovfCnt  = 0;
      oszCnt  = 0;
      holdErr = 0;
   endtask

   // Reset the bench, check the reset-state outputs of instance s, then release
   task automatic doReset(input logic [1:0] s);
      sel      = s;
      aresetn  = 1'b0;
      s_tvalid = 1'b0;
      m_tready = 1'b0;
      s_word   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("rst%0d_s_tready", s), 32'(s_tready_s), 0);
      checkOutput($sformatf("rst%0d_m_tvalid", s), 32'(m_tvalid_s), 0);
      checkOutput($sformatf("rst%0d_level", s), 32'(level_s), 0);
      checkOutput($sformatf("rst%0d_almost_full", s), 32'(almost_full_s), 0);
      aresetn = 1'b1;
      tick();
      clearMonitor();
   endtask

   vec_t vecs[12];
   int   lvl[12] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 0};

   initial begin
      int n;
      int mism;

      // Table for a 5-beat packet through instance 0, cycle by cycle: nothing
      // visible until the tlast beat commits, then 5 beats at one per cycle
      for (int i = 0; i < 12; i++) begin
         vecs[i].sValid    = (i < 5);
         vecs[i].sWord     = (i < 5) ? mk(i, i == 4) : '0;
         vecs[i].mReady    = 1'b1;
         vecs[i].expSReady = 1'b1;
         vecs[i].expMValid = (i >= 6) && (i <= 10);
         vecs[i].expLevel  = 5'(lvl[i]);
         vecs[i].expWord   = (i >= 6 && i <= 10) ? mk(i - 6, i == 10) : '0;
      end

      doReset(2'd0);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkOutput($sformatf("vec%0d_s_tready", i), 32'(s_tready_s), 32'(vecs[i].expSReady));
         checkOutput($sformatf("vec%0d_m_tvalid", i), 32'(m_tvalid_s), 32'(vecs[i].expMValid));
         checkOutput($sformatf("vec%0d_level", i), 32'(level_s), 32'(vecs[i].expLevel));
         if (vecs[i].expMValid) checkOutput($sformatf("vec%0d_word", i), 32'(m_word_s), 32'(vecs[i].expWord));
         tick();
      end
      s_tvalid = 1'b0;

      // Oversize: a 20-beat packet never appears, one oversize pulse, next packet passes
      doReset(2'd0);
      m_tready = 1'b1;
      for (int i = 0; i < 20; i++) sendBeat(mk(i, i == 19));
      repeat (3) tick();
      checkOutput("oversize_no_output", rx_q.size(), 0);
      checkOutput("oversize_pulses", oszCnt, 1);
      checkOutput("oversize_no_overflow", ovfCnt, 0);
      checkOutput("oversize_level", 32'(level_s), 0);
      for (int i = 0; i < 3; i++) sendBeat(mk(100 + i, i == 2));
      waitRx("oversize_next_count", 3, 20);
      for (int i = 0; i < 3 && i < rx_q.size(); i++)
         checkOutput($sformatf("oversize_next_word%0d", i), 32'(rx_q[i]), 32'(mk(100 + i, i == 2)));

      // Word FIFO with backpressure, output stalled: fills to exactly 16
      doReset(2'd3);
      n = 0;
      for (int k = 0; k < 20; k++) begin
         s_tvalid = 1'b1;
         s_word   = mk(n, 1'b0);
         @(negedge clk);
         checkOutput($sformatf("fill%0d_level", k), 32'(level_s), n);
         checkOutput($sformatf("fill%0d_almost_full", k), 32'(almost_full_s), 32'(n >= 12));
         checkOutput($sformatf("fill%0d_s_tready", k), 32'(s_tready_s), 32'(n < 16));
         checkOutput($sformatf("fill%0d_m_tvalid", k), 32'(m_tvalid_s), 32'(n > 0));
         if (n < 16) n++;
         tick();
      end
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      waitRx("fill_drain_count", 16, 40);
      for (int i = 0; i < 16 && i < rx_q.size(); i++)
         checkOutput($sformatf("fill_drain_word%0d", i), 32'(rx_q[i]), 32'(mk(i, 1'b0)));
      checkOutput("fill_drain_level", 32'(level_s), 0);

      // Packet mode without backpressure: packet A kept, packet B dropped once
      doReset(2'd2);
      for (int i = 0; i < 10; i++) sendBeat(mk(i, i == 9));
      for (int i = 0; i < 10; i++) sendBeat(mk(50 + i, i == 9));
      repeat (2) tick();
      checkOutput("ovf_pulses", ovfCnt, 1);
      checkOutput("ovf_no_oversize", oszCnt, 0);
      checkOutput("ovf_level", 32'(level_s), 10);
      checkOutput("ovf_stalled_no_output", rx_q.size(), 0);
      m_tready = 1'b1;
      waitRx("ovf_drain_count", 10, 40);
      for (int i = 0; i < 10 && i < rx_q.size(); i++)
         checkOutput($sformatf("ovf_drain_word%0d", i), 32'(rx_q[i]), 32'(mk(i, i == 9)));
      repeat (5) tick();
      checkOutput("ovf_no_extra", rx_q.size(), 10);
      checkOutput("ovf_final_level", 32'(level_s), 0);

      // Random output stalls over 1000 beats through the registered word FIFO
      doReset(2'd1);
      randDone = 0;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               sendBeat(mk(i, (i % 8) == 7));
               if ($urandom_range(0, 3) == 0) tick();
            end
            randDone = 1;
         end
         begin
            while (!randDone) begin
               m_tready = 1'($urandom_range(0, 1));
               tick();
            end
         end
      join
      m_tready = 1'b1;
      waitRx("rand_count", 1000, 100);
      mism = 0;
      for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== mk(i, (i % 8) == 7)) mism++;
      checkOutput("rand_mismatches", mism, 0);
      checkOutput("rand_hold_violations", holdErr, 0);

      // Asynchronous reset mid-packet, then a clean 4-beat packet
      doReset(2'd0);
      sendBeat(mk(200, 1'b0));
      sendBeat(mk(201, 1'b1));
      for (int i = 0; i < 3; i++) sendBeat(mk(210 + i, 1'b0));
      @(negedge clk);
      checkOutput("prerst_m_tvalid", 32'(m_tvalid_s), 1);
      checkOutput("prerst_level", 32'(level_s), 4);
      @(posedge clk);
      #2;
      aresetn = 1'b0;
      #1;
      checkOutput("asyncrst_m_tvalid", 32'(m_tvalid_s), 0);
      checkOutput("asyncrst_level", 32'(level_s), 0);
      checkOutput("asyncrst_s_tready", 32'(s_tready_s), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      aresetn = 1'b1;
      tick();
      clearMonitor();
      m_tready = 1'b1;
      for (int i = 0; i < 4; i++) sendBeat(mk(220 + i, i == 3));
      waitRx("postrst_count", 4, 20);
      for (int i = 0; i < 4 && i < rx_q.size(); i++)
         checkOutput($sformatf("postrst_word%0d", i), 32'(rx_q[i]), 32'(mk(220 + i, i == 3)));
      checkOutput("postrst_drop_pulses", ovfCnt + oszCnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
